// File: rtl/step_write_arbiter.sv
// Round-robin arbiter for a shared step-write strobe: grant, settle, pulse, gap.
// One requester owns the strobe at a time; the round-robin pointer advances only on a completed pulse.
module step_write_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 3_000_000,
    parameter int unsigned PULSE_CYCLES  = 25_000,
    parameter int unsigned GAP_CYCLES    = 1_000
) (
    input  logic       i_Clock50MHz,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic [3:0] i_Req,
    output logic [3:0] o_Grant,
    output logic       o_StepWrite,
    output logic [3:0] o_Ack,
    output logic       o_Busy,
    output logic [1:0] o_State
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        PULSE  = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] PULSE_LAST  = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 1);

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [3:0]  grant_q;
    logic [3:0]  ack_q;
    logic        step_q;
    logic [1:0]  ptr_q;
    logic [1:0]  own_q;

    logic        win_vld_d;
    logic [1:0]  win_idx_d;
    logic [1:0]  cand;

    // Search upward from the slot after the last served requester.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_vld_d && i_Req[cand]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand;
            end
        end
    end

    always_ff @(posedge i_Clock50MHz or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            step_q  <= 1'b0;
            ptr_q   <= 2'd3;
            own_q   <= 2'd0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    grant_q <= '0;
                    step_q  <= 1'b0;
                    if (i_Enable && win_vld_d) begin
                        state_q <= SETTLE;
                        grant_q <= 4'b0001 << win_idx_d;
                        own_q   <= win_idx_d;
                    end
                end
                SETTLE: begin
                    // A dropped request wins over settle completion on the same edge.
                    if (!i_Req[own_q]) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        cnt_q   <= '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q <= PULSE;
                        step_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q <= GAP;
                        step_q  <= 1'b0;
                        ack_q   <= grant_q;
                        grant_q <= '0;
                        ptr_q   <= own_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_Grant     = grant_q;
    assign o_StepWrite = step_q;
    assign o_Ack       = ack_q;
    assign o_State     = state_q;
    assign o_Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_step_write_arbiter.sv
// Bench for step_write_arbiter: vector table, directed corner sequences and
// randomized traffic against a timeline-based reference model.
module tb_step_write_arbiter;

    localparam int S = 4;
    localparam int P = 3;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'd0;
    logic [3:0] grant;
    logic       step;
    logic [3:0] ack;
    logic       busy;
    logic [1:0] st;

    int nvec = 0;
    int nerr = 0;

    // Reference model: a grant is a timeline anchored at the edge it was issued.
    bit m_active = 1'b0;
    int m_t0     = 0;
    int m_owner  = 0;
    int m_ptr    = 3;
    int m_e      = 0;

    step_write_arbiter #(.SETTLE_CYCLES(S), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .i_Clock50MHz(clk),
        .i_Reset     (rst),
        .i_Enable    (en),
        .i_Req       (req),
        .o_Grant     (grant),
        .o_StepWrite (step),
        .o_Ack       (ack),
        .o_Busy      (busy),
        .o_State     (st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] grant;
        logic       step;
        logic [3:0] ack;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic e_en, input logic [3:0] e_req);
        int p;
        m_e++;
        if (m_active) begin
            p = m_e - 1 - m_t0;
            if (p < S && !e_req[m_owner]) begin
                m_active = 1'b0;
            end else begin
                if (p + 1 == S + P) m_ptr = m_owner;
                if (p + 1 >= S + P + G) m_active = 1'b0;
            end
        end else if (e_en && e_req != 4'd0) begin
            for (int k = 1; k <= 4; k++) begin
                if (!m_active && e_req[(m_ptr + k) % 4]) begin
                    m_active = 1'b1;
                    m_owner  = (m_ptr + k) % 4;
                    m_t0     = m_e;
                end
            end
        end
    endtask

    task automatic model_check();
        int         el;
        logic [1:0] x_st;
        logic [3:0] x_gr;
        logic [3:0] x_ack;
        x_st = 2'd0; x_gr = 4'd0; x_ack = 4'd0;
        if (m_active) begin
            el   = m_e - m_t0;
            x_st = (el < S) ? 2'd1 : (el < S + P) ? 2'd2 : 2'd3;
            x_gr = (el < S + P) ? 4'(1 << m_owner) : 4'd0;
            x_ack = (el == S + P) ? 4'(1 << m_owner) : 4'd0;
        end
        chk("model_state", 32'(st), 32'(x_st));
        chk("model_grant", 32'(grant), 32'(x_gr));
        chk("model_step", 32'(step), 32'(x_st == 2'd2));
        chk("model_ack", 32'(ack), 32'(x_ack));
        chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
        chk("inv_step_state", 32'(step && st != 2'd2), 32'd0);
        chk("inv_busy", 32'(busy), 32'(st != 2'd0));
    endtask

    task automatic tick(input logic t_en, input logic [3:0] t_req);
        en  = t_en;
        req = t_req;
        @(posedge clk);
        model_edge(t_en, t_req);
        #1;
        model_check();
    endtask

    // Asserts reset between edges, checks the immediate effect, releases mid-cycle.
    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = 4'd0;
        #1;
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        m_active = 1'b0;
        m_ptr    = 3;
        #1;
        chk("post_rst_grant", 32'(grant), 32'd0);
    endtask

    initial begin
        logic [3:0] order [5];
        logic [3:0] exp_order [5];
        logic [3:0] prev_g;
        logic       prev_s;
        int ng, ns, na, npulse;
        logic [3:0] rreq;
        logic       ren;

        tbl[0]  = '{1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, 2'd1};
        tbl[1]  = '{1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, 2'd1};
        tbl[2]  = '{1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, 2'd1};
        tbl[3]  = '{1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, 2'd1};
        tbl[4]  = '{1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd2};
        tbl[5]  = '{1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd2};
        tbl[6]  = '{1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd2};
        tbl[7]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd3};
        tbl[8]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd3};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0};
        tbl[10] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0};

        // Single request walk-through.
        #2;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            tick(tbl[i].en, tbl[i].req);
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("tbl%0d_step", i), 32'(step), 32'(tbl[i].step));
            chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_state", i), 32'(st), 32'(tbl[i].st));
        end

        // Round-robin with all requesters asserted.
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        do_reset();
        ng = 0; ns = 0; na = 0;
        prev_g = 4'd0; prev_s = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1'b1, 4'b1111);
            if (grant != 4'd0 && prev_g == 4'd0 && ng < 5) begin
                order[ng] = grant;
                ng++;
            end
            if (step && !prev_s) ns++;
            if (ack != 4'd0) na++;
            prev_g = grant;
            prev_s = step;
        end
        chk("rr_grants", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < ng) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        chk("rr_strobes", 32'(ns), 32'd5);
        chk("rr_acks", 32'(na), 32'd5);

        // Abort in the second settle cycle leaves the pointer alone.
        do_reset();
        tick(1'b1, 4'b0100);
        chk("abort_grant", 32'(grant), 32'b0100);
        tick(1'b1, 4'b0000);
        chk("abort_state", 32'(st), 32'd0);
        chk("abort_grant_clr", 32'(grant), 32'd0);
        chk("abort_step", 32'(step), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        tick(1'b1, 4'b0101);
        chk("abort_next_grant", 32'(grant), 32'b0001);

        // Enable gating in IDLE, ignored during PULSE.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 4'b0010);
            chk("en_idle_state", 32'(st), 32'd0);
            chk("en_idle_busy", 32'(busy), 32'd0);
        end
        tick(1'b1, 4'b0010);
        chk("en_grant", 32'(grant), 32'b0010);
        npulse = 0; na = 0;
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b0010);
        chk("en_pulse_state", 32'(st), 32'd2);
        npulse += int'(step);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 4'b0000);
            npulse += int'(step);
            if (ack == 4'b0010) na++;
        end
        chk("en_pulse_len", 32'(npulse), 32'd3);
        chk("en_ack", 32'(na), 32'd1);

        // Reset in the second PULSE cycle.
        do_reset();
        tick(1'b1, 4'b0001);
        for (int i = 0; i < 5; i++) tick(1'b1, 4'b0001);
        chk("rp_in_pulse", 32'(step), 32'd1);
        do_reset();
        na = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 4'b0000);
            if (ack != 4'd0) na++;
        end
        chk("rp_no_ack", 32'(na), 32'd0);

        // Randomized traffic with sticky requests and occasional resets.
        do_reset();
        rreq = 4'd0;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) rreq[b] = ~rreq[b];
            ren = ($urandom_range(9) != 0);
            if ($urandom_range(199) == 0) do_reset();
            tick(ren, rreq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
